// File: rtl/fifo_pack_pkg.sv
// fifo_pack_pkg: shared types and defaults for the FIFO read packer.
// Holds the packer state enum, width defaults and count-width helper.
package fifo_pack_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int BYTES_PER_WORD_DEF = 4;

  function automatic int cnt_w(input int n);
    return $clog2(n) + 1;
  endfunction

  localparam int CNT_W = cnt_w(BYTES_PER_WORD_DEF);

  typedef enum logic [1:0] {
    FILL,
    WAIT,
    OUT
  } state_t;

endpackage

// File: rtl/fifo_pack_timer.sv
// fifo_pack_timer: idle counter for partial-word flush.
// Counts enabled cycles; expire fires on the TIMEOUT_CYCLES-th one.
module fifo_pack_timer #(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [TW-1:0] cnt;

  assign expire = en && (cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr || expire) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fifo_rd_packer.sv
// fifo_rd_packer: drains the byte FIFO and packs little-endian words.
// Define FIFO_PACK_TIMEOUT_EN to flush partial words after idle time.
module fifo_rd_packer
  import fifo_pack_pkg::*;
#(
  parameter int DATA_WIDTH     = DATA_WIDTH_DEF,
  parameter int BYTES_PER_WORD = BYTES_PER_WORD_DEF,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 fifo_empty,
  output logic                                 fifo_rd_n,
  input  logic [DATA_WIDTH-1:0]                fifo_data,
  input  logic                                 fifo_under_flow,
  output logic [DATA_WIDTH*BYTES_PER_WORD-1:0] word_data,
  output logic [$clog2(BYTES_PER_WORD):0]      word_bytes,
  output logic                                 word_valid,
  input  logic                                 word_ready,
  output logic                                 err_underflow
);

  localparam int CW = cnt_w(BYTES_PER_WORD);
  localparam int WW = DATA_WIDTH * BYTES_PER_WORD;

  state_t        state;
  state_t        state_nx;
  logic [CW-1:0] count;
  logic [CW-1:0] count_nx;
  logic [WW-1:0] word_q;
  logic          err_q;
  logic          capture;
  logic          expire;

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end

`ifdef FIFO_PACK_TIMEOUT_EN
  logic idle_en;

  assign idle_en = (state == FILL) && (count != '0) && fifo_empty;

  fifo_pack_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (!idle_en),
    .en    (idle_en),
    .expire(expire)
  );
`else
  assign expire = 1'b0;
`endif

  assign capture = (state == WAIT) && !fifo_under_flow;

  always_comb begin
    state_nx = state;
    count_nx = count;
    unique case (state)
      FILL: begin
        if (!fifo_empty) begin
          state_nx = WAIT;
        end else if (expire) begin
          state_nx = OUT;
        end
      end
      WAIT: begin
        if (!fifo_under_flow) begin
          count_nx = count + 1'b1;
        end
        state_nx = (count_nx == CW'(BYTES_PER_WORD)) ? OUT : FILL;
      end
      OUT: begin
        if (word_ready) begin
          state_nx = FILL;
          count_nx = '0;
        end
      end
      default: begin
        state_nx = FILL;
        count_nx = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= FILL;
      count  <= '0;
      word_q <= '0;
      err_q  <= 1'b0;
    end else begin
      state <= state_nx;
      count <= count_nx;
      err_q <= (state == WAIT) && fifo_under_flow;
      if ((state == OUT) && word_ready) begin
        word_q <= '0;
      end else if (capture) begin
        for (int i = 0; i < BYTES_PER_WORD; i++) begin
          if (count == CW'(i)) begin
            word_q[i*DATA_WIDTH +: DATA_WIDTH] <= fifo_data;
          end
        end
      end
    end
  end

  // Read only from FILL, so strobes are always at least two cycles apart.
  assign fifo_rd_n     = !rst_n || (state != FILL) || fifo_empty;
  assign word_valid    = (state == OUT);
  assign word_bytes    = count;
  assign word_data     = word_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_fifo_rd_packer.sv
// tb_fifo_rd_packer: randomized bench with a queue-based FIFO model
// and an expected-byte scoreboard for the packed words.
module tb_fifo_rd_packer;

  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fifo_empty;
  logic        fifo_rd_n;
  logic [7:0]  fifo_data;
  logic        fifo_under_flow;
  logic [31:0] word_data;
  logic [2:0]  word_bytes;
  logic        word_valid;
  logic        word_ready;
  logic        err_underflow;

  fifo_rd_packer #(
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fifo_empty     (fifo_empty),
    .fifo_rd_n      (fifo_rd_n),
    .fifo_data      (fifo_data),
    .fifo_under_flow(fifo_under_flow),
    .word_data      (word_data),
    .word_bytes     (word_bytes),
    .word_valid     (word_valid),
    .word_ready     (word_ready),
    .err_underflow  (err_underflow)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0] fq[$];
  logic [7:0] pend[$];
  logic [7:0] exp_q[$];
  int rd_cycles[$];

  bit uf_arm = 0;
  int uf_skip = 0;
  bit rand_ready = 0;
  bit hold_arm = 0;
  int hold = 0;
  int cyc = 0;
  int words = 0;
  int uf_seen = 0;
  int valid_len = 0;
  int last_valid_len = 0;
  int first_valid_cyc = 0;
  int last_rd = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, want);
    end
  endtask

  task automatic push(input logic [7:0] b, input bit keep);
    pend.push_back(b);
    if (keep) exp_q.push_back(b);
  endtask

  task automatic wait_drain(input int maxc, input string tag);
    int n = 0;
    while ((exp_q.size() > 0 || pend.size() > 0 || word_valid) && n < maxc) begin
      @(negedge clk);
      n++;
    end
    chk(tag, 32'(n < maxc), 32'd1);
  endtask

  task automatic check_word();
    int n;
    logic [31:0] w;
    w = '0;
    if (exp_q.size() == 0) begin
      chk("word_unexpected", 32'(word_valid), 32'd0);
      return;
    end
    n = (exp_q.size() >= 4) ? 4 : exp_q.size();
    for (int i = 0; i < n; i++) w[i*8 +: 8] = exp_q.pop_front();
    chk("word_data", word_data, w);
    chk("word_bytes", 32'(word_bytes), 32'(n));
  endtask

  // Behavioural FIFO: registered empty, one-cycle read latency.
  initial begin
    logic rd_s;
    fifo_empty = 1'b1;
    fifo_data = '0;
    fifo_under_flow = 1'b0;
    forever begin
      @(negedge clk);
      #4;
      rd_s = fifo_rd_n;
      @(posedge clk);
      if (!rd_s) begin
        if (fq.size() > 0) begin
          fifo_data <= fq.pop_front();
          if (uf_arm && uf_skip == 0) begin
            fifo_under_flow <= 1'b1;
            uf_arm = 0;
          end else begin
            fifo_under_flow <= 1'b0;
            if (uf_arm) uf_skip--;
          end
        end else begin
          fifo_under_flow <= 1'b1;
        end
      end else begin
        fifo_under_flow <= 1'b0;
      end
      while (pend.size() > 0 && fq.size() < 16) fq.push_back(pend.pop_front());
      fifo_empty <= (fq.size() == 0);
    end
  end

  // Output monitor and word_ready driver.
  initial begin
    bit prev_rd_low = 0;
    bit prev_err = 0;
    bit prev_valid = 0;
    bit acc_prev = 0;
    logic [31:0] held_data = '0;
    logic [2:0] held_bytes = '0;
    word_ready = 1'b1;
    forever begin
      @(negedge clk);
      #2;
      cyc++;
      if (!rst_n) begin
        prev_rd_low = 0;
        prev_err = 0;
        prev_valid = 0;
        acc_prev = 0;
        valid_len = 0;
        continue;
      end
      if (!fifo_rd_n) begin
        chk("rd_gap", 32'(prev_rd_low), 32'd0);
        chk("rd_in_out", 32'(word_valid), 32'd0);
        rd_cycles.push_back(cyc);
        last_rd = cyc;
      end
      if (acc_prev && !fifo_empty) chk("next_rd", 32'(fifo_rd_n), 32'd0);
      if (err_underflow) begin
        uf_seen++;
        chk("uf_pulse", 32'(prev_err), 32'd0);
      end
      acc_prev = 0;
      if (word_valid) begin
        valid_len++;
        if (!prev_valid) begin
          first_valid_cyc = cyc;
          if (hold_arm) begin
            hold = 10;
            hold_arm = 0;
          end
        end else begin
          chk("hold_data", word_data, held_data);
          chk("hold_bytes", 32'(word_bytes), 32'(held_bytes));
        end
        held_data = word_data;
        held_bytes = word_bytes;
      end
      if (hold > 0) begin
        word_ready = 1'b0;
        hold--;
      end else begin
        word_ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
      end
      if (word_valid && word_ready) begin
        check_word();
        acc_prev = 1;
        last_valid_len = valid_len;
        valid_len = 0;
        words++;
      end
      prev_rd_low = !fifo_rd_n;
      prev_err = err_underflow;
      prev_valid = word_valid;
    end
  end

  task automatic chk_reset(input string tag);
    chk({tag, "_rd_n"}, 32'(fifo_rd_n), 32'd1);
    chk({tag, "_valid"}, 32'(word_valid), 32'd0);
    chk({tag, "_data"}, word_data, 32'd0);
    chk({tag, "_bytes"}, 32'(word_bytes), 32'd0);
    chk({tag, "_err"}, 32'(err_underflow), 32'd0);
  endtask

  initial begin
    int w0;
    int u0;
    int n;
    int kept;
    int ui;
    int nb;
    rst_n = 1'b0;
    // Preload during reset: strobe must stay high though FIFO is non-empty.
    push(8'h11, 1);
    push(8'h22, 1);
    push(8'h33, 1);
    push(8'h44, 1);
    repeat (3) @(negedge clk);
    chk("rst_fifo_nonempty", 32'(fifo_empty), 32'd0);
    chk_reset("rst");
    rd_cycles.delete();
    rst_n = 1'b1;

    wait_drain(100, "t1_drain");
    @(negedge clk);
    chk("t1_nrd", 32'(rd_cycles.size()), 32'd4);
    if (rd_cycles.size() == 4) begin
      for (int i = 0; i < 3; i++)
        chk("t1_rd_space", 32'(rd_cycles[i+1] - rd_cycles[i]), 32'd2);
      chk("t1_valid_rise", 32'(first_valid_cyc - rd_cycles[3]), 32'd2);
    end
    chk("t1_valid_len", 32'(last_valid_len), 32'd1);

    hold_arm = 1;
    w0 = words;
    for (int i = 0; i < 8; i++) push(8'(8'h80 + i), 1);
    wait_drain(200, "t2_drain");
    chk("t2_words", 32'(words - w0), 32'd2);

    u0 = uf_seen;
    uf_arm = 1;
    uf_skip = 1;
    push(8'hA0, 1);
    push(8'hA1, 0);
    push(8'hA2, 1);
    push(8'hA3, 1);
    push(8'hA4, 1);
    wait_drain(200, "t3_drain");
    chk("t3_uf", 32'(uf_seen - u0), 32'd1);

    w0 = words;
    push(8'hB1, 1);
    push(8'hB2, 1);
    repeat (12) @(negedge clk);
    chk("t4_no_word", 32'(words - w0), 32'd0);
    rst_n = 1'b0;
    @(negedge clk);
    chk_reset("t4_rst");
    exp_q.delete();
    rst_n = 1'b1;
    for (int i = 1; i <= 4; i++) push(8'(i), 1);
    wait_drain(100, "t4_drain");
    chk("t4_words", 32'(words - w0), 32'd1);

    w0 = words;
    push(8'h5A, 1);
    push(8'h5B, 1);
`ifdef FIFO_PACK_TIMEOUT_EN
    n = 0;
    while (!word_valid && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("t5_flush_seen", 32'(n < 200), 32'd1);
    @(negedge clk);
    chk("t5_flush_lat", 32'(first_valid_cyc - last_rd), 32'(TO + 2));
    wait_drain(50, "t5_drain");
    chk("t5_words", 32'(words - w0), 32'd1);
`else
    n = 0;
    repeat (200) begin
      @(negedge clk);
      if (word_valid) n++;
    end
    chk("t5_no_flush", 32'(n), 32'd0);
    push(8'h5C, 1);
    push(8'h5D, 1);
    wait_drain(100, "t5_drain");
    chk("t5_words", 32'(words - w0), 32'd1);
`endif

    rand_ready = 1;
    kept = 0;
    ui = 0;
    u0 = uf_seen;
    for (int it = 0; it < 60; it++) begin
      repeat ($urandom_range(0, 6)) @(negedge clk);
      if (fq.size() == 0 && pend.size() == 0 && $urandom_range(0, 7) == 0) begin
        uf_arm = 1;
        uf_skip = 0;
        push(8'($urandom), 0);
        ui++;
      end
      nb = $urandom_range(1, 3);
      for (int j = 0; j < nb; j++) push(8'($urandom), 1);
      kept += nb;
    end
    while (kept % 4 != 0) begin
      push(8'($urandom), 1);
      kept++;
    end
    wait_drain(3000, "t6_drain");
    @(negedge clk);
    chk("t6_uf", 32'(uf_seen - u0), 32'(ui));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
